// File: rtl/el2_trace_pack_pkg.sv
// Trace packet, header and FIFO entry types shared by
// the trace serializer and its buffer.
package el2_trace_pack_pkg;

  localparam logic [3:0] TRACE_SYNC = 4'hA;

  typedef struct packed {
    logic [31:0] trace_rv_i_insn_ip;
    logic [31:0] trace_rv_i_address_ip;
    logic        trace_rv_i_valid_ip;
    logic        trace_rv_i_exception_ip;
    logic [4:0]  trace_rv_i_ecause_ip;
    logic        trace_rv_i_interrupt_ip;
    logic [31:0] trace_rv_i_tval_ip;
  } el2_trace_pkt_t;

  typedef struct packed {
    logic [3:0] sync;
    logic       exception;
    logic       interrupt;
    logic [4:0] ecause;
    logic       has_tval;
    logic [1:0] wcm1;
    logic [1:0] rsvd;
    logic [7:0] drop;
    logic [7:0] seq;
  } el2_trace_hdr_t;

  typedef enum logic [2:0] {
    TR_IDLE,
    TR_HDR,
    TR_ADDR,
    TR_INSN,
    TR_TVAL
  } el2_trace_st_t;

  // The valid bit is implied by presence in the FIFO.
  typedef struct packed {
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exception;
    logic        interrupt;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic [7:0]  seq;
    logic [7:0]  drop;
  } el2_trace_ent_t;

  function automatic logic [31:0] trace_hdr(
    input el2_trace_ent_t e
  );
    el2_trace_hdr_t h;
    h.sync      = TRACE_SYNC;
    h.exception = e.exception;
    h.interrupt = e.interrupt;
    h.ecause    = e.ecause;
    h.has_tval  = e.exception | e.interrupt;
    h.wcm1      = h.has_tval ? 2'd3 : 2'd2;
    h.rsvd      = 2'b00;
    h.drop      = e.drop;
    h.seq       = e.seq;
    return h;
  endfunction

endpackage

// File: rtl/el2_trace_pack_fifo.sv
// Synchronous FIFO holding captured trace entries;
// head entry is read combinationally.
module el2_trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/el2_trace_pack.sv
// Retire trace capture: buffers packets and serializes
// each into 3 or 4 framed words on a valid/ready port.
module el2_trace_pack
  import el2_trace_pack_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   trace_en,
  input  logic [103:0]           trace_pkt,
  output logic                   tr_valid,
  output logic [31:0]            tr_data,
  output logic                   tr_last,
  input  logic                   tr_ready,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow_sticky,
  input  logic                   clr_overflow
);

  el2_trace_pkt_t pkt;
  el2_trace_ent_t ent_in;
  el2_trace_ent_t head;
  el2_trace_st_t  state;
  el2_trace_st_t  state_nxt;

  logic              full;
  logic              empty;
  logic              cap;
  logic              do_push;
  logic              do_drop;
  logic              accept;
  logic              pop;
  logic              more;
  logic              has_tval;
  logic [7:0]        seq;
  logic [DROP_W-1:0] drop_cnt;
  logic [7:0]        drop8;

  assign pkt     = el2_trace_pkt_t'(trace_pkt);
  assign cap     = trace_en & pkt.trace_rv_i_valid_ip;
  assign do_push = cap & ~full;
  assign do_drop = cap & full;

  // Header carries 8 bits; wider counters saturate into it.
  generate
    if (DROP_W <= 8) begin : g_drop_ext
      assign drop8 = 8'(drop_cnt);
    end else begin : g_drop_sat
      assign drop8 = (|drop_cnt[DROP_W-1:8]) ? 8'hFF
                                              : drop_cnt[7:0];
    end
  endgenerate

  always_comb begin
    ent_in           = '0;
    ent_in.insn      = pkt.trace_rv_i_insn_ip;
    ent_in.addr      = pkt.trace_rv_i_address_ip;
    ent_in.exception = pkt.trace_rv_i_exception_ip;
    ent_in.interrupt = pkt.trace_rv_i_interrupt_ip;
    ent_in.ecause    = pkt.trace_rv_i_ecause_ip;
    ent_in.tval      = pkt.trace_rv_i_tval_ip;
    ent_in.seq       = seq;
    ent_in.drop      = drop8;
  end

  el2_trace_fifo #(
    .WIDTH ($bits(el2_trace_ent_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .din   (ent_in),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign has_tval = head.exception | head.interrupt;
  assign accept   = tr_valid & tr_ready;
  assign pop      = accept & tr_last;
  // Another entry remains after this pop (or arrives now).
  assign more     = do_push |
                    (fifo_count != ($clog2(DEPTH)+1)'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      TR_IDLE: if (~empty | do_push) state_nxt = TR_HDR;
      TR_HDR:  if (accept) state_nxt = TR_ADDR;
      TR_ADDR: if (accept) state_nxt = TR_INSN;
      TR_INSN: begin
        if (accept) begin
          if (has_tval)  state_nxt = TR_TVAL;
          else if (more) state_nxt = TR_HDR;
          else           state_nxt = TR_IDLE;
        end
      end
      TR_TVAL: begin
        if (accept) state_nxt = more ? TR_HDR : TR_IDLE;
      end
      default: state_nxt = TR_IDLE;
    endcase
  end

  always_comb begin
    tr_valid = (state != TR_IDLE);
    tr_data  = '0;
    tr_last  = 1'b0;
    case (state)
      TR_HDR:  tr_data = trace_hdr(head);
      TR_ADDR: tr_data = head.addr;
      TR_INSN: begin
        tr_data = head.insn;
        tr_last = ~has_tval;
      end
      TR_TVAL: begin
        tr_data = head.tval;
        tr_last = 1'b1;
      end
      default: tr_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= TR_IDLE;
      seq             <= '0;
      drop_cnt        <= '0;
      overflow_sticky <= 1'b0;
    end else begin
      state <= state_nxt;
      if (do_push) begin
        seq      <= seq + 8'd1;
        drop_cnt <= '0;
      end else if (do_drop && drop_cnt != '1) begin
        drop_cnt <= drop_cnt + DROP_W'(1);
      end
      if (do_drop) begin
        overflow_sticky <= 1'b1;
      end else if (clr_overflow) begin
        overflow_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_el2_trace_pack.sv
// Randomized bench for el2_trace_pack against a word-queue
// model, plus directed literal checks.
module tb_el2_trace_pack;
  import el2_trace_pack_pkg::*;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         trace_en = 1'b0;
  logic [103:0] trace_pkt;
  logic         tr_valid;
  logic [31:0]  tr_data;
  logic         tr_last;
  logic         tr_ready = 1'b1;
  logic [3:0]   fifo_count;
  logic         overflow_sticky;
  logic         clr_overflow = 1'b0;

  el2_trace_pkt_t ps = '0;
  assign trace_pkt = ps;

  always #5 clk = ~clk;

  el2_trace_pack #(.DEPTH(DEPTH), .DROP_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .trace_en        (trace_en),
    .trace_pkt       (trace_pkt),
    .tr_valid        (tr_valid),
    .tr_data         (tr_data),
    .tr_last         (tr_last),
    .tr_ready        (tr_ready),
    .fifo_count      (fifo_count),
    .overflow_sticky (overflow_sticky),
    .clr_overflow    (clr_overflow)
  );

  int pass_n = 0;
  int tot_n  = 0;
  bit chk_on = 0;

  function automatic void chk(string nm, logic [31:0] got,
                              logic [31:0] exp);
    tot_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s got=%h exp=%h", nm, got, exp);
  endfunction

  // Model: pending output words in order, packets in FIFO.
  typedef struct {
    logic [31:0] d;
    bit          last;
  } wrd_t;

  wrd_t     wq[$];
  int       pkt_n = 0;
  int       m_seq = 0;
  int       m_drop = 0;
  bit       m_sticky = 0;

  always @(posedge clk) begin
    if (rst) begin
      wq.delete();
      pkt_n = 0; m_seq = 0; m_drop = 0; m_sticky = 0;
    end else begin
      int  n0;
      bit  dropped;
      bit  tv;
      n0 = pkt_n;
      dropped = 0;
      if (wq.size() != 0 && tr_ready) begin
        if (wq[0].last) pkt_n--;
        void'(wq.pop_front());
      end
      if (trace_en && ps.trace_rv_i_valid_ip) begin
        if (n0 == DEPTH) begin
          dropped = 1;
          if (m_drop < 255) m_drop++;
        end else begin
          logic [31:0] h;
          tv = ps.trace_rv_i_exception_ip |
               ps.trace_rv_i_interrupt_ip;
          h = 32'hA000_0000
            + (32'(ps.trace_rv_i_exception_ip) << 27)
            + (32'(ps.trace_rv_i_interrupt_ip) << 26)
            + (32'(ps.trace_rv_i_ecause_ip) << 21)
            + (32'(tv) << 20)
            + ((tv ? 32'd3 : 32'd2) << 18)
            + (32'(m_drop) << 8) + 32'(m_seq);
          wq.push_back('{h, 0});
          wq.push_back('{ps.trace_rv_i_address_ip, 0});
          wq.push_back('{ps.trace_rv_i_insn_ip, !tv});
          if (tv) wq.push_back('{ps.trace_rv_i_tval_ip, 1});
          pkt_n++;
          m_seq = (m_seq + 1) % 256;
          m_drop = 0;
        end
      end
      if (dropped) m_sticky = 1;
      else if (clr_overflow) m_sticky = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_valid", 32'(tr_valid), 32'(wq.size() != 0));
      chk("m_count", 32'(fifo_count), 32'(pkt_n));
      chk("m_sticky", 32'(overflow_sticky), 32'(m_sticky));
      if (wq.size() != 0 && tr_valid) begin
        chk("m_data", tr_data, wq[0].d);
        chk("m_last", 32'(tr_last), 32'(wq[0].last));
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] i,
                       input logic e, input logic it,
                       input logic [4:0] ec, input logic [31:0] tv);
    trace_en = 1'b1;
    ps.trace_rv_i_valid_ip     = 1'b1;
    ps.trace_rv_i_address_ip   = a;
    ps.trace_rv_i_insn_ip      = i;
    ps.trace_rv_i_exception_ip = e;
    ps.trace_rv_i_interrupt_ip = it;
    ps.trace_rv_i_ecause_ip    = ec;
    ps.trace_rv_i_tval_ip      = tv;
  endtask

  task automatic rand_pkt();
    logic e;
    e = ($urandom % 4 == 0);
    drive($urandom, $urandom, e, !e && ($urandom % 8 == 0),
          5'($urandom), $urandom);
    ps.trace_rv_i_valid_ip = ($urandom % 2 == 0);
  endtask

  logic [31:0] hdrs [9];
  int          nh;
  bit          first;
  bit          pushed;
  bit          drained;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_on = 1;
    @(negedge clk);
    chk("rst_valid", 32'(tr_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_sticky", 32'(overflow_sticky), 32'd0);
    chk("rst_data", tr_data, 32'd0);

    // Single plain packet
    drive(32'h8000_0000, 32'h0000_0013, 0, 0, 5'd0, 32'd0);
    @(negedge clk); ps.trace_rv_i_valid_ip = 1'b0;
    chk("p1_hdr", tr_data, 32'hA008_0000);
    chk("p1_cnt", 32'(fifo_count), 32'd1);
    @(negedge clk); chk("p1_addr", tr_data, 32'h8000_0000);
    @(negedge clk); chk("p1_insn", tr_data, 32'h0000_0013);
    chk("p1_last", 32'(tr_last), 32'd1);
    @(negedge clk); chk("p1_idle", 32'(tr_valid), 32'd0);
    chk("p1_cnt0", 32'(fifo_count), 32'd0);

    // Exception packet
    drive(32'h0000_0100, 32'h0000_0073, 1, 0, 5'd2, 32'hDEAD_BEEF);
    @(negedge clk); ps.trace_rv_i_valid_ip = 1'b0;
    chk("p2_hdr", tr_data, 32'hA85C_0001);
    @(negedge clk); @(negedge clk);
    chk("p2_insn_nl", 32'(tr_last), 32'd0);
    @(negedge clk); chk("p2_tval", tr_data, 32'hDEAD_BEEF);
    chk("p2_last", 32'(tr_last), 32'd1);
    @(negedge clk);

    // Stall mid-packet
    drive(32'h0000_2000, 32'h0000_0033, 0, 0, 5'd0, 32'd0);
    @(negedge clk); ps.trace_rv_i_valid_ip = 1'b0;
    @(negedge clk); tr_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("st_data", tr_data, 32'h0000_2000);
      chk("st_last", 32'(tr_last), 32'd0);
    end
    tr_ready = 1'b1;
    @(negedge clk); chk("st_insn", tr_data, 32'h0000_0033);
    @(negedge clk);

    // Overflow: 11 pushes into a stalled DEPTH=8 FIFO
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    tr_ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      drive(32'h1000 + 32'(k) * 4, 32'(k), 0, 0, 5'd0, 32'd0);
      @(negedge clk);
    end
    ps.trace_rv_i_valid_ip = 1'b0;
    chk("ov_cnt", 32'(fifo_count), 32'd8);
    chk("ov_sticky", 32'(overflow_sticky), 32'd1);
    hdrs[0] = tr_data; nh = 1; first = tr_last;
    tr_ready = 1'b1; pushed = 0;
    for (int c = 0; c < 200 && nh < 9; c++) begin
      @(negedge clk);
      ps.trace_rv_i_valid_ip = 1'b0;
      if (tr_valid) begin
        if (first) begin hdrs[nh] = tr_data; nh++; end
        first = tr_last;
      end
      if (!pushed && fifo_count < 8) begin
        drive(32'h0000_9000, 32'h0000_0093, 0, 0, 5'd0, 32'd0);
        pushed = 1;
      end
    end
    chk("ov_nhdr", 32'(nh), 32'd9);
    if (nh == 9) begin
      chk("ov_h0", 32'(hdrs[0][15:0]), 32'h0000);
      chk("ov_h7", 32'(hdrs[7][15:0]), 32'h0007);
      chk("ov_h8", hdrs[8], 32'hA008_0308);
    end
    drained = 0;
    for (int c = 0; c < 50 && !drained; c++) begin
      @(negedge clk);
      drained = (fifo_count == 0) && !tr_valid;
    end
    chk("ov_drain", 32'(drained), 32'd1);
    clr_overflow = 1'b1; @(negedge clk); clr_overflow = 1'b0;
    chk("ov_clr", 32'(overflow_sticky), 32'd0);

    // Back-to-back with random trace_en
    for (int c = 0; c < 80; c++) begin
      rand_pkt();
      ps.trace_rv_i_valid_ip = 1'b1;
      trace_en = ($urandom % 4 != 0);
      @(negedge clk);
    end

    // Fully random traffic
    for (int c = 0; c < 3000; c++) begin
      rand_pkt();
      trace_en     = ($urandom % 8 != 0);
      tr_ready     = ($urandom % 3 != 0);
      clr_overflow = ($urandom % 16 == 0);
      rst          = ($urandom % 300 == 0);
      @(negedge clk);
    end
    rst = 1'b0; clr_overflow = 1'b0; tr_ready = 1'b1;
    ps.trace_rv_i_valid_ip = 1'b0;

    // Reset during the ADDR word
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    drive(32'h0000_4000, 32'h0000_0013, 0, 0, 5'd0, 32'd0);
    @(negedge clk); ps.trace_rv_i_valid_ip = 1'b0;
    drive(32'h0000_5000, 32'h0000_0013, 0, 0, 5'd0, 32'd0);
    @(negedge clk); ps.trace_rv_i_valid_ip = 1'b0;
    chk("mr_addr", tr_data, 32'h0000_4000);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("mr_valid", 32'(tr_valid), 32'd0);
    chk("mr_cnt", 32'(fifo_count), 32'd0);
    drive(32'h0000_6000, 32'h0000_0013, 0, 0, 5'd0, 32'd0);
    @(negedge clk); ps.trace_rv_i_valid_ip = 1'b0;
    chk("mr_hdr", tr_data, 32'hA008_0000);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

endmodule
